// File: rtl/flash_spi_pkg.sv
// Shared opcode, frame-length and FSM state definitions for the SPI flash read engine.
// SPI_FAST_READ_EN selects opcode 0x0B with 8 dummy clocks; undefined gives plain 0x03 read.
package flash_spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, RELEASE} state_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADR_BITS   = 24;
  localparam int DUMMY_BITS = 8;
  localparam int DATA_BITS  = 16;

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] OPCODE = OP_FAST_READ;
  localparam int DUMMY_USED = DUMMY_BITS;
`else
  localparam logic [7:0] OPCODE = OP_READ;
  localparam int DUMMY_USED = 0;
`endif

  // Index of the first SCK cycle whose MISO bit belongs to the read data.
  localparam int DATA_START = CMD_BITS + ADR_BITS + DUMMY_USED;
  localparam int FRAME_BITS = DATA_START + DATA_BITS;

endpackage

// File: rtl/spi_sck_tick.sv
// SCK half-period divider: rise/fall strobes every CLK_DIV clk cycles while en is high.
// Strobes are combinational from the counter; dropping en clears it so the next frame starts with SCK low.
module spi_sck_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt;
  logic       phase;
  logic       tick;

  assign tick = en && (cnt == 8'(CLK_DIV - 1));
  assign rise = tick && !phase;
  assign fall = tick && phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_flash_rd_engine.sv
// SPI mode-0 flash read of one 16-bit word; ack 2 + N*2*CLK_DIV cycles after ce is sampled.
// Requester holds ce until ack; ce low mid-frame aborts. SPI_FAST_READ_EN adds 0x0B + dummy clocks.
module spi_flash_rd_engine
  import flash_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [23:0] adr,
  output logic        ack,
  output logic [15:0] dat_o,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_clk,
  output logic        spi_seln
);

  state_t      state, state_nxt;
  logic [31:0] sh_out;
  logic [15:0] sh_in;
  logic [5:0]  bit_cnt;
  logic        rise, fall;
  logic        last_bit;

  spi_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == SHIFT),
    .rise (rise),
    .fall (fall)
  );

  assign last_bit = (bit_cnt == 6'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ce) state_nxt = SETUP;
      SETUP:   state_nxt = ce ? SHIFT : IDLE;
      SHIFT: begin
        if (!ce)                  state_nxt = IDLE;
        else if (fall && last_bit) state_nxt = DONE;
      end
      DONE:    state_nxt = RELEASE;
      RELEASE: if (!ce) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_out   <= '0;
      sh_in    <= '0;
      bit_cnt  <= '0;
      ack      <= 1'b0;
      dat_o    <= '0;
      spi_mosi <= 1'b0;
      spi_clk  <= 1'b0;
      spi_seln <= 1'b1;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (ce) begin
            sh_out   <= {OPCODE, adr};
            spi_mosi <= OPCODE[7];
            spi_seln <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        SETUP, SHIFT: begin
          if (!ce) begin
            spi_seln <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
          end else if (rise) begin
            spi_clk <= 1'b1;
            if (bit_cnt >= 6'(DATA_START)) sh_in <= {sh_in[14:0], spi_miso};
          end else if (fall) begin
            // Zeros shift in behind the address, so MOSI idles low through dummy/data clocks.
            spi_clk  <= 1'b0;
            bit_cnt  <= bit_cnt + 6'd1;
            sh_out   <= sh_out << 1;
            spi_mosi <= sh_out[30];
          end
        end
        DONE: begin
          ack      <= 1'b1;
          spi_seln <= 1'b1;
          spi_mosi <= 1'b0;
          dat_o    <= {sh_in[7:0], sh_in[15:8]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd_engine.sv
// Two engines (CLK_DIV 2 and 1) against a behavioural SPI flash; ack words scoreboarded from a queue.
module tb_spi_flash_rd_engine;

`ifdef SPI_FAST_READ_EN
  localparam int          NBITS  = 56;
  localparam int          DSTART = 40;
  localparam logic [7:0]  OP     = 8'h0B;
`else
  localparam int          NBITS  = 48;
  localparam int          DSTART = 32;
  localparam logic [7:0]  OP     = 8'h03;
`endif
  localparam int LAT0 = 2 + NBITS * 2 * 2;
  localparam int LAT1 = 2 + NBITS * 2 * 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ce, ack, mosi, miso, sck, seln;
  logic [23:0] adr [2];
  logic [15:0] dat [2];

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {logic ch; logic [15:0] dat;} exp_t;
  exp_t exp_q [$];

  typedef struct {int ch; logic [23:0] adr; int hold; int lat; logic [15:0] dat;} vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  spi_flash_rd_engine #(.CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce[0]), .adr(adr[0]), .ack(ack[0]), .dat_o(dat[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]), .spi_clk(sck[0]), .spi_seln(seln[0])
  );

  spi_flash_rd_engine #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce[1]), .adr(adr[1]), .ack(ack[1]), .dat_o(dat[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]), .spi_clk(sck[1]), .spi_seln(seln[1])
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a == 24'h400000) return 8'h34;
    if (a == 24'h400001) return 8'h12;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return {mem_byte(a + 24'd1), mem_byte(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash model and monitors, all sampled on the falling clk edge.
  int          cyc = 0;
  int          scnt [2];
  int          last_rise [2];
  int          high_cnt [2];
  int          ack_cnt [2];
  logic [31:0] cmd [2];
  logic        sck_q [2];
  logic        seln_q [2];
  int          k;
  logic [7:0]  b;
  exp_t        e;

  initial begin
    for (int c = 0; c < 2; c++) begin
      scnt[c] = 0; last_rise[c] = -1; high_cnt[c] = 0; ack_cnt[c] = 0;
      cmd[c] = '0; sck_q[c] = 1'b0; seln_q[c] = 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int c = 0; c < 2; c++) begin
      if (seln[c] !== 1'b0) begin
        scnt[c] = 0;
        miso[c] = 1'b0;
        last_rise[c] = -1;
        high_cnt[c]++;
      end else begin
        if (seln_q[c]) begin
          check("seln_gap_ge2", 32'(high_cnt[c] >= 2), 32'd1);
          high_cnt[c] = 0;
        end
        if (sck[c] && !sck_q[c]) begin
          if (scnt[c] < 32) cmd[c] = {cmd[c][30:0], mosi[c]};
          scnt[c]++;
          if (last_rise[c] >= 0) check("sck_period", 32'(cyc - last_rise[c]), 32'(c == 0 ? 4 : 2));
          last_rise[c] = cyc;
        end
        if (!sck[c] && sck_q[c] && scnt[c] >= DSTART && scnt[c] < DSTART + 16) begin
          k = scnt[c] - DSTART;
          b = (k < 8) ? mem_byte(cmd[c][23:0]) : mem_byte(cmd[c][23:0] + 24'd1);
          miso[c] = b[3'(7 - (k % 8))];
        end
      end
      if (ack[c] === 1'b1) begin
        ack_cnt[c]++;
        check("ack_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ack_chan", 32'(c), 32'(e.ch));
          check("dat_o", 32'(dat[c]), 32'(e.dat));
        end
      end
      sck_q[c]  = sck[c];
      seln_q[c] = seln[c];
    end
  end

  task automatic xfer(input vec_t v);
    int lat;
    int bad;
    @(negedge clk);
    ce[v.ch]  = 1'b1;
    adr[v.ch] = v.adr;
    exp_q.push_back({v.ch[0], v.dat});
    @(posedge clk);
    #1 adr[v.ch] = ~v.adr;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
      if (ack[v.ch]) break;
    end
    check("latency", 32'(lat), 32'(v.lat));
    check("mosi_cmd", cmd[v.ch], {OP, v.adr});
    bad = 0;
    repeat (v.hold) begin
      @(posedge clk);
      #1;
      if (ack[v.ch] || !seln[v.ch]) bad++;
    end
    if (v.hold > 0) check("held_ce_single", 32'(bad), 32'd0);
    @(negedge clk);
    ce[v.ch] = 1'b0;
  endtask

  task automatic wait_bits(input int ch, input int nbits);
    int w;
    w = 0;
    @(negedge clk);
    #1;
    while (scnt[ch] < nbits && w < 1000) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("reach_bit", 32'(scnt[ch]), 32'(nbits));
  endtask

  initial begin
    int acks0;
    int bad;
    tbl[0] = '{0, 24'h400000, 20, LAT0, 16'h1234};
    tbl[1] = '{1, 24'h7FFFFE, 0,  LAT1, mem_word(24'h7FFFFE)};
    tbl[2] = '{1, 24'h000000, 0,  LAT1, mem_word(24'h000000)};
    tbl[3] = '{0, 24'h4ABCDE, 0,  LAT0, mem_word(24'h4ABCDE)};
    tbl[4] = '{0, 24'hA5A5A5, 3,  LAT0, mem_word(24'hA5A5A5)};
    tbl[5] = '{1, 24'h123456, 0,  LAT1, mem_word(24'h123456)};

    rst_n = 1'b0;
    ce = '0;
    adr[0] = '0;
    adr[1] = '0;
    #17;
    for (int c = 0; c < 2; c++) begin
      check("rst_seln", 32'(seln[c]), 32'd1);
      check("rst_sck", 32'(sck[c]), 32'd0);
      check("rst_mosi_ack", 32'({mosi[c], ack[c]}), 32'd0);
      check("rst_dat", 32'(dat[c]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    xfer(tbl[0]);

    // Abort: drop ce once the flash has seen 20 SCK rises.
    @(negedge clk);
    ce[0]  = 1'b1;
    adr[0] = 24'h123456;
    wait_bits(0, 20);
    ce[0] = 1'b0;
    acks0 = ack_cnt[0];
    @(posedge clk);
    #1;
    check("abort_seln", 32'(seln[0]), 32'd1);
    check("abort_sck", 32'(sck[0]), 32'd0);
    repeat (250) @(posedge clk);
    #1;
    check("abort_no_ack", 32'(ack_cnt[0] - acks0), 32'd0);
    check("abort_dat_kept", 32'(dat[0]), 32'h1234);

    // Reset asserted during the data phase.
    @(negedge clk);
    ce[0]  = 1'b1;
    adr[0] = 24'h400000;
    wait_bits(0, DSTART + 4);
    rst_n = 1'b0;
    ce[0] = 1'b0;
    #1;
    check("mid_rst_seln", 32'(seln[0]), 32'd1);
    check("mid_rst_sck", 32'(sck[0]), 32'd0);
    check("mid_rst_dat", 32'(dat[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acks0 = ack_cnt[0];
    bad = 0;
    repeat (250) begin
      @(posedge clk);
      #1;
      if (!seln[0]) bad++;
    end
    check("post_rst_no_ack", 32'(ack_cnt[0] - acks0), 32'd0);
    check("post_rst_idle_seln", 32'(bad), 32'd0);

    for (int i = 1; i < 6; i++) xfer(tbl[i]);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_flash_rd_engine.md
SPI_FLASH_RD_ENGINE -- requirements
Module: spi_flash_rd_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk cycles per SCK half-period (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ce  input  1  read request, level; held high by requester until ack.
REQ-005 SHALL have port adr  input  24  flash byte address of the first byte.
REQ-006 SHALL have port ack  output  1  one-cycle pulse; dat_o valid.
REQ-007 SHALL have port dat_o  output  16  read word.
REQ-008 SHALL have port spi_mosi  output  1  serial data to flash.
REQ-009 SHALL have port spi_miso  input  1  serial data from flash.
REQ-010 SHALL have port spi_clk  output  1  SCK.
REQ-011 SHALL have port spi_seln  output  1  chip select, active low.

Function
REQ-012 SHALL implement states IDLE, SETUP, SHIFT, DONE, RELEASE.
REQ-013 IDLE: ce=1 at an edge SHALL latch adr, load the command frame, drive spi_seln=0, and enter SETUP.
REQ-014 SETUP SHALL last exactly one clk cycle with spi_clk=0, MOSI carrying the first frame bit; then SHIFT.
REQ-015 SHIFT SHALL use SPI mode 0: SCK idle low; MOSI changes on SCK falling edge; MISO sampled on SCK rising edge.
REQ-016 Each SCK half-period SHALL be exactly CLK_DIV clk cycles.
REQ-017 Frame SHALL be MSB-first: opcode 0x03 (8 bits), adr[23:0] (24 bits), 16 data bits; N=48 SCK cycles.
REQ-018 First received byte (address adr) SHALL land in dat_o[7:0], second (adr+1) in dat_o[15:8].
REQ-019 After the final SCK falling edge, DONE SHALL drive spi_seln=1 and ack=1 for exactly one cycle, with dat_o updated in the same cycle.
REQ-020 Latency from the edge sampling ce=1 in IDLE to ack high SHALL be exactly 2 + N*2*CLK_DIV clk cycles (194 for defaults).
REQ-021 RELEASE SHALL hold until ce=0 is sampled, then return to IDLE; a held ce never starts a second transfer.
REQ-022 ce=0 sampled in SETUP or SHIFT SHALL abort: spi_seln=1 and spi_clk=0 at the next edge, no ack, dat_o unchanged, go to IDLE.
REQ-023 adr changes after the start edge SHALL be ignored.
REQ-024 dat_o SHALL hold its last value between transfers.
REQ-025 spi_seln SHALL stay high for at least 2 clk cycles between consecutive transfers.

Reset
REQ-026 rst_n=0 SHALL, asynchronously, force state IDLE, spi_seln=1, spi_clk=0, spi_mosi=0, ack=0, dat_o=16'h0000, and clear all counters.
REQ-027 Reset asserted mid-transfer SHALL abort it; no ack after rst_n deasserts until a new ce.

Configuration
REQ-028 Macro SPI_FAST_READ_EN defined: opcode SHALL be 0x0B, followed by 8 dummy SCK cycles after the address, with MISO ignored; N=56, latency 226 for defaults.
REQ-029 Macro undefined: opcode SHALL be 0x03 with no dummy cycles, per REQ-017.

Structure
REQ-030 Package flash_spi_pkg SHALL hold the opcode constants, the state enum typedef, and the bit-count constants (CMD 8, ADR 24, DUMMY 8, DATA 16).
REQ-031 Sub-module spi_sck_tick SHALL generate the half-period tick and the rise/fall strobes from CLK_DIV; the FSM and shift registers stay in spi_flash_rd_engine.

Verification
REQ-032 Reset, then ce=1, adr=24'h400000, flash model returns 0x34,0x12 -> MOSI shows 0x03,0x40,0x00,0x00; ack after 194 cycles; dat_o=16'h1234.
REQ-033 ce held high 20 cycles past ack -> exactly one transfer; spi_seln stays high until ce drops and a new ce arrives.
REQ-034 ce dropped in SHIFT at bit 20 -> spi_seln=1 next edge; no ack; dat_o keeps previous value 16'h1234.
REQ-035 rst_n pulsed low during data phase -> spi_seln=1, spi_clk=0 immediately; dat_o=0; next request completes normally.
REQ-036 CLK_DIV=1, back-to-back requests at adr 24'h7FFFFE then 24'h000000 -> SCK period 2 clk; latency 98; both words correct; seln high >=2 cycles between.
REQ-037 SPI_FAST_READ_EN defined, adr=24'h4ABCDE -> opcode 0x0B, 8 dummy clocks; ack after 226 cycles; correct data.
